// File: rtl/uart_cmd_bridge_if.sv
// Memory and test-sequencer bus of the UART command bridge.
// master: bridge side (drives strobes/address/data); slave: memory/sequencer side.
interface uart_cmd_bridge_if #(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 4
) ();
    logic                    test_start;
    logic                    test_done;
    logic [31:0]             pass_count;
    logic [31:0]             fail_count;
    logic                    mem_we;
    logic                    mem_re;
    logic [8*ADDR_BYTES-1:0] mem_addr;
    logic [8*DATA_BYTES-1:0] mem_wdata;
    logic [8*DATA_BYTES-1:0] mem_rdata;
    logic                    mem_rvalid;

    modport master (
        output test_start, mem_we, mem_re, mem_addr, mem_wdata,
        input  test_done, pass_count, fail_count, mem_rdata, mem_rvalid
    );

    modport slave (
        input  test_start, mem_we, mem_re, mem_addr, mem_wdata,
        output test_done, pass_count, fail_count, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: 8N1 receiver, command engine, TX response FIFO, 8N1 serialiser.
// Ports: clk, rst_n (async active-low), uart_rx/uart_tx (serial, idle high),
//   bus (uart_cmd_bridge_if.master: mem_we/re/addr/wdata/rdata/rvalid, test_start/done,
//   pass_count/fail_count), busy (engine not idle), err_flags ([0] framing, [1] overrun).
// Optional: define UART_CMD_TIMEOUT_EN to abort commands stalled between bytes.
module uart_cmd_bridge #(
    parameter int CLOCK_FREQ    = 100_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int ADDR_BYTES    = 4,
    parameter int DATA_BYTES    = 4,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              uart_tx,
    uart_cmd_bridge_if.master bus,
    output logic              busy,
    output logic [1:0]        err_flags
);
    localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
    localparam int CW   = $clog2(CPB) + 1;
    localparam int AW   = 8 * ADDR_BYTES;
    localparam int DW   = 8 * DATA_BYTES;
    localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int FAW  = $clog2(TX_FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);

    // ---------------- RX ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_s1_q, rx_s_q, rx_p_q;
    logic          rx_valid, rx_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_p_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s_q     <= rx_s1_q;
            rx_p_q     <= rx_s_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // Start needs a falling edge, so a line stuck low after a bad stop
    // bit is not mistaken for a new frame.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_p_q && !rx_s_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == FULL) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == FULL) begin
                rx_state_d = RX_IDLE;
                rx_valid   = rx_s_q;
                rx_ferr    = !rx_s_q;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    logic [7:0]     fifo_mem [TX_FIFO_DEPTH];
    logic [FAW-1:0] wptr_q, rptr_q;
    logic [FAW:0]   count_q;
    logic           push, pop, do_push, fifo_full, fifo_empty;
    logic [7:0]     push_data, fifo_rdata;

    assign fifo_full  = (count_q == (FAW+1)'(TX_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign do_push    = push && (!fifo_full || pop);
    assign fifo_rdata = fifo_mem[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + FAW'(1);
            if (pop) rptr_q <= rptr_q + FAW'(1);
            unique case ({do_push, pop})
                2'b10:   count_q <= count_q + (FAW+1)'(1);
                2'b01:   count_q <= count_q - (FAW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- TX ----------------
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [8:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d, tx_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '1;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
        end
    end

    // Bit 0 is the start bit, 1..8 data, 9 stop; the next byte is
    // loaded at the end of the stop bit so frames abut.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        tx_load    = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_load  = !fifo_empty;
            end
            TX_BUSY: if (tx_cnt_q == FULL) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_load = !fifo_empty;
                    if (fifo_empty) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_d     = tx_sh_q[0];
                    tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_sh_d    = {1'b1, fifo_rdata};
            tx_d       = 1'b0;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_BUSY;
        end
    end

    assign pop     = tx_load;
    assign uart_tx = tx_q;

    // ---------------- Engine ----------------
    typedef enum logic [2:0] {E_IDLE, E_ADDR, E_DATA, E_RD_WAIT, E_REPLY} eng_state_e;
    eng_state_e     state_q, state_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic           wr_q, wr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [63:0]    rbuf_q, rbuf_d;
    logic [3:0]     rlen_q, rlen_d;
    logic [7:0]     tmo_q, tmo_d;
    logic [1:0]     err_q, err_d;
    logic           we_q, we_d, re_q, re_d, start_q, start_d;

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [31:0] IDLE_LIMIT = 32'(160 * CPB);
    logic [31:0] idle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else if ((state_q == E_ADDR || state_q == E_DATA) && !rx_valid)
            idle_q <= idle_q + 32'd1;
        else idle_q <= '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= E_IDLE;
            bcnt_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rlen_q  <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rlen_q  <= rlen_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            we_q    <= we_d;
            re_q    <= re_d;
            start_q <= start_d;
        end
    end

    // Every reply is staged in rbuf and drained LSB first from REPLY.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rlen_d  = rlen_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        start_d = 1'b0;
        push    = 1'b0;
        if (rx_ferr) err_d[0] = 1'b1;
        unique case (state_q)
            E_IDLE: if (rx_valid) begin
                state_d = E_REPLY;
                rlen_d  = 4'd1;
                bcnt_d  = '0;
                case (rx_sh_q)
                    8'h57: begin wr_d = 1'b1; state_d = E_ADDR; end
                    8'h52: begin wr_d = 1'b0; state_d = E_ADDR; end
                    8'h53: begin start_d = 1'b1; rbuf_d = 64'h4B; end
                    8'h44: rbuf_d = bus.test_done ? 64'h31 : 64'h30;
                    8'h50: begin rbuf_d = 64'(bus.pass_count); rlen_d = 4'd4; end
                    8'h46: begin rbuf_d = 64'(bus.fail_count); rlen_d = 4'd4; end
                    8'h45: begin rbuf_d = 64'(err_q); err_d = 2'b00; end
                    default: rbuf_d = 64'h4E;
                endcase
            end
            E_ADDR: if (rx_valid) begin
                addr_d = (addr_q >> 8) | (AW'(rx_sh_q) << (AW - 8));
                bcnt_d = bcnt_q + BCW'(1);
                if (bcnt_q == BCW'(ADDR_BYTES - 1)) begin
                    bcnt_d = '0;
                    if (wr_q) state_d = E_DATA;
                    else begin
                        re_d    = 1'b1;
                        tmo_d   = '0;
                        state_d = E_RD_WAIT;
                    end
                end
            end
            E_DATA: if (rx_valid) begin
                wdata_d = (wdata_q >> 8) | (DW'(rx_sh_q) << (DW - 8));
                bcnt_d  = bcnt_q + BCW'(1);
                if (bcnt_q == BCW'(DATA_BYTES - 1)) begin
                    bcnt_d  = '0;
                    we_d    = 1'b1;
                    rbuf_d  = 64'h4B;
                    rlen_d  = 4'd1;
                    state_d = E_REPLY;
                end
            end
            E_RD_WAIT: begin
                if (rx_valid) err_d[1] = 1'b1;
                if (bus.mem_rvalid) begin
                    rbuf_d  = 64'(bus.mem_rdata);
                    rlen_d  = 4'(DATA_BYTES);
                    state_d = E_REPLY;
                end else if (tmo_q == 8'hFF) begin
                    rbuf_d  = 64'h54;
                    rlen_d  = 4'd1;
                    state_d = E_REPLY;
                end else tmo_d = tmo_q + 8'd1;
            end
            E_REPLY: begin
                if (rx_valid) err_d[1] = 1'b1;
                if (!fifo_full) begin
                    push   = 1'b1;
                    rbuf_d = rbuf_q >> 8;
                    rlen_d = rlen_q - 4'd1;
                    if (rlen_q == 4'd1) state_d = E_IDLE;
                end
            end
            default: state_d = E_IDLE;
        endcase
`ifdef UART_CMD_TIMEOUT_EN
        if ((state_q == E_ADDR || state_q == E_DATA) && !rx_valid &&
            idle_q >= IDLE_LIMIT) begin
            bcnt_d  = '0;
            rbuf_d  = 64'h54;
            rlen_d  = 4'd1;
            state_d = E_REPLY;
        end
`endif
    end

    assign push_data      = rbuf_q[7:0];
    assign busy           = (state_q != E_IDLE);
    assign err_flags      = err_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_re     = re_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.test_start = start_q;
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed self-checking bench for uart_cmd_bridge.
// Drives serial commands, decodes serial replies, models a simple memory.
module tb_uart_cmd_bridge;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic       uart_tx;
    logic       busy;
    logic [1:0] err_flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rxq[$];
    int         stq[$];

    int          mem_lat = 0;
    logic [31:0] mem_val = '0;
    int          we_cnt = 0, re_cnt = 0, st_cnt = 0;
    logic [31:0] we_addr, we_data, re_addr;

    uart_cmd_bridge_if #(.ADDR_BYTES(4), .DATA_BYTES(4)) bus_if ();

    uart_cmd_bridge #(
        .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000),
        .ADDR_BYTES(4), .DATA_BYTES(4), .TX_FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .bus(bus_if), .busy(busy), .err_flags(err_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus_if.mem_we === 1'b1) begin
            we_cnt++;
            we_addr = bus_if.mem_addr;
            we_data = bus_if.mem_wdata;
        end
        if (bus_if.mem_re === 1'b1) begin
            re_cnt++;
            re_addr = bus_if.mem_addr;
        end
        if (bus_if.test_start === 1'b1) st_cnt++;
    end

    initial begin
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus_if.mem_re === 1'b1 && mem_lat > 0) begin
                repeat (mem_lat) @(posedge clk);
                #1 bus_if.mem_rvalid = 1'b1;
                bus_if.mem_rdata = mem_val;
                @(posedge clk);
                #1 bus_if.mem_rvalid = 1'b0;
            end
        end
    end

    initial begin : serial_rx
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                checks++;
                if (uart_tx !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_stop: got %b want 1", uart_tx);
                end
                rxq.push_back(b);
                stq.push_back(t0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1 uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1 uart_rx = 1'b1;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        ok = (rxq.size() >= n);
    endtask

    task automatic clear_rx();
        rxq.delete();
        stq.delete();
    endtask

    task automatic test_reset();
        uart_rx = 1'b1;
        bus_if.test_done  = 1'b0;
        bus_if.pass_count = 32'h0102_0304;
        bus_if.fail_count = 32'hA5B6_C7D8;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++; $display("FAIL rst_tx: got %b want 1", uart_tx);
        end
        checks++;
        if ({bus_if.mem_we, bus_if.mem_re, bus_if.test_start} !== 3'b000) begin
            errors++;
            $display("FAIL rst_strobes: got %b want 000",
                     {bus_if.mem_we, bus_if.mem_re, bus_if.test_start});
        end
        checks++;
        if (bus_if.mem_addr !== 32'h0 || bus_if.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_addr_data: got %h/%h want 0/0",
                     bus_if.mem_addr, bus_if.mem_wdata);
        end
        checks++;
        if (busy !== 1'b0 || err_flags !== 2'b00) begin
            errors++;
            $display("FAIL rst_busy_err: got %b/%b want 0/00", busy, err_flags);
        end
    endtask

    task automatic test_write();
        logic [7:0] cmd [9] = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00,
                                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int w0 = we_cnt;
        bit ok;
        clear_rx();
        for (int i = 0; i < 9; i++) send_byte(cmd[i], 1'b1);
        wait_bytes(1, 400, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h4B) begin
            errors++; $display("FAIL write_reply: got %h want 4b", ok ? rxq[0] : 8'hxx);
        end
        checks++;
        if (we_cnt - w0 != 1) begin
            errors++; $display("FAIL write_pulse: got %0d cycles want 1", we_cnt - w0);
        end
        checks++;
        if (we_addr !== 32'h10 || we_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_bus: got %h/%h want 00000010/deadbeef", we_addr, we_data);
        end
    endtask

    task automatic test_read();
        logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int r0 = re_cnt;
        bit ok;
        clear_rx();
        mem_lat = 5;
        mem_val = 32'hDEAD_BEEF;
        send_byte(8'h52, 1'b1);
        send_byte(8'h10, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        wait_bytes(4, 1200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL read_count: got %0d bytes want 4", rxq.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i < rxq.size() && rxq[i] !== exp[i]) begin
                errors++; $display("FAIL read_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
        checks++;
        if (re_cnt - r0 != 1 || re_addr !== 32'h10) begin
            errors++;
            $display("FAIL read_req: got %0d/%h want 1/00000010", re_cnt - r0, re_addr);
        end
    endtask

    task automatic test_read_timeout();
        int t_end;
        bit ok;
        clear_rx();
        mem_lat = 0;
        send_byte(8'h52, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h20, 1'b1);
        t_end = cyc;
        repeat (100) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rdwait_busy: got %b want 1", busy);
        end
        wait_bytes(1, 600, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h54) begin
            errors++; $display("FAIL rdto_reply: got %h want 54", ok ? rxq[0] : 8'hxx);
        end
        checks++;
        if (ok && (stq[0] - t_end < 240 || stq[0] - t_end > 270)) begin
            errors++;
            $display("FAIL rdto_delay: got %0d cycles want 240..270", stq[0] - t_end);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rdto_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_counts();
        logic [7:0] exp [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
        bit ok;
        clear_rx();
        send_byte(8'h50, 1'b1);
        wait_bytes(4, 1000, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL pass_count: got %0d bytes want 4", rxq.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i < rxq.size() && rxq[i] !== exp[i]) begin
                errors++; $display("FAIL pass_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (i < stq.size() && stq[i] - stq[i-1] != 10 * CPB) begin
                errors++;
                $display("FAIL frame_spacing%0d: got %0d want %0d",
                         i, stq[i] - stq[i-1], 10 * CPB);
            end
        end
        clear_rx();
        send_byte(8'h46, 1'b1);
        wait_bytes(4, 1000, ok);
        checks++;
        if (!ok || {rxq[3], rxq[2], rxq[1], rxq[0]} !== 32'hA5B6_C7D8) begin
            errors++; $display("FAIL fail_count: got %0d bytes want a5b6c7d8 LSB first",
                               rxq.size());
        end
        clear_rx();
        send_byte(8'h5A, 1'b1);
        wait_bytes(1, 400, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h4E) begin
            errors++; $display("FAIL unknown_op: got %h want 4e", ok ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_seq();
        int s0 = st_cnt;
        bit ok;
        clear_rx();
        send_byte(8'h53, 1'b1);
        wait_bytes(1, 400, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h4B || st_cnt - s0 != 1) begin
            errors++;
            $display("FAIL start: got reply %h pulses %0d want 4b/1",
                     ok ? rxq[0] : 8'hxx, st_cnt - s0);
        end
        bus_if.test_done = 1'b1;
        clear_rx();
        send_byte(8'h44, 1'b1);
        wait_bytes(1, 400, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h31) begin
            errors++; $display("FAIL done_hi: got %h want 31", ok ? rxq[0] : 8'hxx);
        end
        bus_if.test_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_rx();
        send_byte(8'h44, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_bytes(2, 600, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h30 || rxq[1] !== 8'h30) begin
            errors++; $display("FAIL b2b_done: got %0d bytes want 30 30", rxq.size());
        end
        checks++;
        if (err_flags !== 2'b00) begin
            errors++; $display("FAIL b2b_err: got %b want 00", err_flags);
        end
    endtask

    task automatic test_framing();
        bit ok;
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (err_flags !== 2'b01) begin
            errors++; $display("FAIL ferr_flag: got %b want 01", err_flags);
        end
        clear_rx();
        send_byte(8'h45, 1'b1);
        wait_bytes(1, 400, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h01) begin
            errors++; $display("FAIL ferr_report: got %h want 01", ok ? rxq[0] : 8'hxx);
        end
        clear_rx();
        send_byte(8'h45, 1'b1);
        wait_bytes(1, 400, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h00) begin
            errors++; $display("FAIL ferr_cleared: got %h want 00", ok ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        clear_rx();
        mem_lat = 0;
        send_byte(8'h52, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_bytes(1, 600, ok);
        repeat (400) @(negedge clk);
        checks++;
        if (!ok || rxq.size() != 1 || rxq[0] !== 8'h54) begin
            errors++; $display("FAIL ovr_reply: got %0d bytes want single 54", rxq.size());
        end
        checks++;
        if (err_flags !== 2'b10) begin
            errors++; $display("FAIL ovr_flag: got %b want 10", err_flags);
        end
        clear_rx();
        send_byte(8'h45, 1'b1);
        wait_bytes(1, 400, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h02) begin
            errors++; $display("FAIL ovr_report: got %h want 02", ok ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_midframe();
        int k = 0;
        clear_rx();
        send_byte(8'h50, 1'b1);
        while (uart_tx !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++; $display("FAIL midrst_start: got %b want 0", uart_tx);
        end
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got tx %b busy %b want 1/0", uart_tx, busy);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        clear_rx();
        repeat (600) @(posedge clk);
        checks++;
        if (rxq.size() != 0 || uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL midrst_flush: got %0d bytes tx %b want 0/1", rxq.size(), uart_tx);
        end
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_cmd_timeout();
        int w0 = we_cnt;
        bit ok;
        clear_rx();
        send_byte(8'h57, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_bytes(1, 200 * 10 * CPB, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h54 || we_cnt != w0) begin
            errors++;
            $display("FAIL cmd_timeout: got %h we %0d want 54/0",
                     ok ? rxq[0] : 8'hxx, we_cnt - w0);
        end
        clear_rx();
        send_byte(8'h44, 1'b1);
        wait_bytes(1, 400, ok);
        checks++;
        if (!ok || rxq[0] !== 8'h30) begin
            errors++; $display("FAIL after_timeout: got %h want 30", ok ? rxq[0] : 8'hxx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_timeout();
        test_counts();
        test_seq();
        test_back_to_back();
        test_framing();
        test_overrun();
`ifdef UART_CMD_TIMEOUT_EN
        test_cmd_timeout();
`endif
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
